// File: rtl/trig_pkg.sv
// Shared definitions for the DAQ trigger responder: state encoding and default widths.
package trig_pkg;

   localparam int unsigned MISSED_W       = 8;
   localparam int unsigned SAMP_W_DEFAULT = 10;
   localparam int unsigned HOLD_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcq  = 2'd1,
      StRead = 2'd2,
      StHold = 2'd3
   } daq_state_e;

endpackage

// File: rtl/sat_ctr.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_ctr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/daq_trig_responder.sv
// Trigger responder: accepts a trigger, fills the sample buffer, then requests readout.
// Define DAQ_HOLDOFF_EN to build in the HOLD state, the holdoff_len port and its counter.
module daq_trig_responder
   import trig_pkg::*;
#(
   parameter int unsigned SAMP_W = SAMP_W_DEFAULT,
   parameter int unsigned HOLD_W = HOLD_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                trig_in,
   input  logic                trig_strb_in,
   input  logic                run,
   input  logic [SAMP_W-1:0]   acq_len,
   input  logic                rd_done,
`ifdef DAQ_HOLDOFF_EN
   input  logic [HOLD_W-1:0]   holdoff_len,
`endif
   output logic                trig_rdy,
   output logic                acq_en,
   output logic [SAMP_W-1:0]   samp_addr,
   output logic                rd_req,
   output logic                strb_flag,
   output logic [MISSED_W-1:0] missed_ctr,
   output logic [1:0]          state
);

   if (SAMP_W < 1 || HOLD_W < 1) begin : g_bad_width
      $error("daq_trig_responder: SAMP_W and HOLD_W must be at least 1");
   end

   daq_state_e        state_d, state_q;
   logic              trig_rdy_d, trig_rdy_q;
   logic              acq_en_d, acq_en_q;
   logic [SAMP_W-1:0] samp_addr_d, samp_addr_q;
   logic [SAMP_W-1:0] last_d, last_q;
   logic              rd_req_d, rd_req_q;
   logic              strb_d, strb_q;
`ifdef DAQ_HOLDOFF_EN
   logic [HOLD_W-1:0] hold_d, hold_q;
`endif
   logic              miss_inc;

   // Any trigger the FSM cannot accept while enabled counts as missed.
   assign miss_inc = run && trig_in && (state_q != StIdle);

   always_comb begin
      state_d     = state_q;
      acq_en_d    = acq_en_q;
      samp_addr_d = samp_addr_q;
      last_d      = last_q;
      rd_req_d    = rd_req_q;
      strb_d      = strb_q;
`ifdef DAQ_HOLDOFF_EN
      hold_d      = hold_q;
`endif
      if (!run) begin
         state_d     = StIdle;
         acq_en_d    = 1'b0;
         rd_req_d    = 1'b0;
         samp_addr_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (trig_in) begin
                  state_d     = StAcq;
                  acq_en_d    = 1'b1;
                  samp_addr_d = '0;
                  strb_d      = trig_strb_in;
                  // Length is frozen here; zero behaves as a single sample.
                  last_d      = (acq_len == '0) ? '0 : acq_len - SAMP_W'(1);
               end
            end
            StAcq: begin
               if (acq_en_q) begin
                  if (samp_addr_q == last_q) begin
                     state_d     = StRead;
                     acq_en_d    = 1'b0;
                     samp_addr_d = '0;
                     rd_req_d    = 1'b1;
                  end else begin
                     samp_addr_d = samp_addr_q + SAMP_W'(1);
                  end
               end
            end
            StRead: begin
               if (rd_done) begin
                  rd_req_d = 1'b0;
`ifdef DAQ_HOLDOFF_EN
                  state_d  = StHold;
                  hold_d   = (holdoff_len == '0) ? '0 : holdoff_len - HOLD_W'(1);
`else
                  state_d  = StIdle;
`endif
               end
            end
`ifdef DAQ_HOLDOFF_EN
            StHold: begin
               if (hold_q == '0) begin
                  state_d = StIdle;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
`endif
            default: begin
               state_d = StIdle;
            end
         endcase
      end
      // Registered from the next state so an accepted trigger drops it on the same edge.
      trig_rdy_d = (state_d == StIdle) && run;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= StIdle;
         trig_rdy_q  <= 1'b0;
         acq_en_q    <= 1'b0;
         samp_addr_q <= '0;
         last_q      <= '0;
         rd_req_q    <= 1'b0;
         strb_q      <= 1'b0;
`ifdef DAQ_HOLDOFF_EN
         hold_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         trig_rdy_q  <= trig_rdy_d;
         acq_en_q    <= acq_en_d;
         samp_addr_q <= samp_addr_d;
         last_q      <= last_d;
         rd_req_q    <= rd_req_d;
         strb_q      <= strb_d;
`ifdef DAQ_HOLDOFF_EN
         hold_q      <= hold_d;
`endif
      end
   end

   sat_ctr #(
      .WIDTH (MISSED_W)
   ) u_missed_ctr (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (miss_inc),
      .clr   (1'b0),
      .count (missed_ctr)
   );

   assign trig_rdy  = trig_rdy_q;
   assign acq_en    = acq_en_q;
   assign samp_addr = samp_addr_q;
   assign rd_req    = rd_req_q;
   assign strb_flag = strb_q;
   assign state     = state_q;

endmodule

// File: tb/tb_daq_trig_responder.sv
// Bench for daq_trig_responder: directed scenarios then random traffic against a behavioural model.
module tb_daq_trig_responder;

   localparam int SW = 10;
   localparam int HW = 8;
`ifdef DAQ_HOLDOFF_EN
   localparam int EXP_RDY_DELAY = 6;
`else
   localparam int EXP_RDY_DELAY = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_b = 1'b1;
   logic          trig_in = 1'b0;
   logic          trig_strb_in = 1'b0;
   logic          run = 1'b0;
   logic          rd_done = 1'b0;
   logic [SW-1:0] acq_len = 10'd4;
`ifdef DAQ_HOLDOFF_EN
   logic [HW-1:0] holdoff_len = 8'd5;
`endif
   logic          trig_rdy, acq_en, rd_req, strb_flag;
   logic [SW-1:0] samp_addr;
   logic [7:0]    missed_ctr;
   logic [1:0]    state;

   // Model: phase 0 idle, 1 acquiring, 2 awaiting readout, 3 holdoff
   int m_phase, m_addr, m_missed, m_left, m_hold_left;
   bit m_rdy, m_acq, m_rd, m_strb;
   int n_pass = 0;
   int n_total = 0;
   int cnt;

   always #5 clk = ~clk;

   daq_trig_responder #(
      .SAMP_W (SW),
      .HOLD_W (HW)
   ) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .trig_in      (trig_in),
      .trig_strb_in (trig_strb_in),
      .run          (run),
      .acq_len      (acq_len),
      .rd_done      (rd_done),
`ifdef DAQ_HOLDOFF_EN
      .holdoff_len  (holdoff_len),
`endif
      .trig_rdy     (trig_rdy),
      .acq_en       (acq_en),
      .samp_addr    (samp_addr),
      .rd_req       (rd_req),
      .strb_flag    (strb_flag),
      .missed_ctr   (missed_ctr),
      .state        (state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_phase = 0; m_addr = 0; m_missed = 0; m_left = 0; m_hold_left = 0;
      m_rdy = 0; m_acq = 0; m_rd = 0; m_strb = 0;
   endtask

   task automatic model_update();
      int ph;
      ph = m_phase;
      if (!rst_b) begin
         model_reset();
         return;
      end
      if (run && trig_in && ph != 0 && m_missed < 255) m_missed++;
      if (!run) begin
         m_phase = 0; m_acq = 0; m_rd = 0; m_addr = 0;
      end else begin
         case (ph)
            0: if (trig_in) begin
               m_phase = 1; m_acq = 1; m_addr = 0; m_strb = trig_strb_in;
               m_left = (acq_len == 0) ? 1 : int'(acq_len);
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = 2; m_acq = 0; m_addr = 0; m_rd = 1;
               end else begin
                  m_addr++;
               end
            end
            2: if (rd_done) begin
               m_rd = 0;
`ifdef DAQ_HOLDOFF_EN
               m_phase = 3;
               m_hold_left = (holdoff_len == 0) ? 1 : int'(holdoff_len);
`else
               m_phase = 0;
`endif
            end
            default: begin
               m_hold_left--;
               if (m_hold_left == 0) m_phase = 0;
            end
         endcase
      end
      m_rdy = (m_phase == 0) && run;
   endtask

   task automatic check_all();
      check("state", state, m_phase);
      check("trig_rdy", trig_rdy, m_rdy);
      check("acq_en", acq_en, m_acq);
      check("samp_addr", samp_addr, m_addr);
      check("rd_req", rd_req, m_rd);
      check("strb_flag", strb_flag, m_strb);
      check("missed_ctr", missed_ctr, m_missed);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   initial begin
      model_reset();
      // Reset values before any clock edge
      #1 rst_b = 1'b0;
      #1 check_all();
      tick();
      tick();
      rst_b = 1'b1;
      tick();
      tick();
      check("rdy_low_run0", trig_rdy, 0);
      run = 1'b1;
      tick();
      check("rdy_after_reset", trig_rdy, 1);

      // acq_len=4: four samples then readout request
      acq_len = 10'd4;
      trig_in = 1'b1; trig_strb_in = 1'b1;
      tick();
      trig_in = 1'b0; trig_strb_in = 1'b0;
      check("acc_acq_en", acq_en, 1);
      check("acc_trig_rdy", trig_rdy, 0);
      check("acc_strb", strb_flag, 1);
      repeat (4) tick();
      check("rd_req_up", rd_req, 1);

      // Three triggers during readout, then drain
      for (int i = 0; i < 3; i++) begin
         trig_in = 1'b1; tick();
         trig_in = 1'b0; tick();
      end
      check("missed_3", missed_ctr, 3);
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      cnt = 1;
      while (trig_rdy !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      check("rdy_delay", cnt, EXP_RDY_DELAY);

      // Saturation of the missed counter during a long acquisition
      acq_len = 10'd1023;
      trig_in = 1'b1; tick();
      for (int i = 0; i < 300; i++) begin
         trig_in = 1'b1; tick();
         trig_in = 1'b0; tick();
      end
      check("missed_sat", missed_ctr, 255);
      check("still_acq", state, 1);

      // Abort mid-acquisition at samp_addr=2
      run = 1'b0; tick();
      run = 1'b1; tick();
      acq_len = 10'd8;
      trig_in = 1'b1; tick();
      trig_in = 1'b0;
      tick(); tick();
      check("abort_addr", samp_addr, 2);
      run = 1'b0; tick();
      check("abort_state", state, 0);
      check("abort_acq_en", acq_en, 0);
      check("abort_rdy", trig_rdy, 0);
      check("abort_missed", missed_ctr, 255);
      tick();
      check("abort_rdy2", trig_rdy, 0);
      run = 1'b1; tick();
      check("rerun_rdy", trig_rdy, 1);

      // acq_len=0 behaves as one sample
      acq_len = 10'd0;
      trig_in = 1'b1; tick();
      trig_in = 1'b0;
      check("len0_acq_en", acq_en, 1);
      tick();
      check("len0_acq_off", acq_en, 0);
      check("len0_read", state, 2);

      // Asynchronous reset during readout
      @(posedge clk);
      model_update();
      #3 rst_b = 1'b0;
      #1;
      model_reset();
      check_all();
      check("async_state", state, 0);
      check("async_rd_req", rd_req, 0);
      check("async_missed", missed_ctr, 0);
      tick();
      rst_b = 1'b1;
      tick();

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         run = ($urandom_range(0, 39) != 0);
         trig_in = ($urandom_range(0, 4) == 0);
         trig_strb_in = $urandom_range(0, 1) == 1;
         rd_done = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 9) == 0) acq_len = SW'($urandom_range(0, 12));
`ifdef DAQ_HOLDOFF_EN
         if ($urandom_range(0, 9) == 0) holdoff_len = HW'($urandom_range(0, 6));
`endif
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
